// File: rtl/am29_pkg.sv
// Shared FSM state encoding and elaboration-time helpers for the bus FIFO latch driver.
package am29_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOAD  = 2'd2,
    DRIVE = 2'd3
  } state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// DEPTH x WIDTH FIFO storage with pointers, count and flags.
// Optional registered almost_full/almost_empty flags under BUS_FIFO_ALMOST_EN.
module bus_fifo_mem
  import am29_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] head_nxt,
  output logic             full,
  output logic             empty,
`ifdef BUS_FIFO_ALMOST_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [AW:0]      cnt_n;
  logic             push;
  logic             pull;

  // full/empty reflect the start-of-cycle count, so a write while full is dropped
  // even if a pop frees a slot on the same edge.
  assign push     = wr && !full;
  assign pull     = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign rd_nxt   = rd_ptr + 1'b1;
  assign head     = mem[rd_ptr];
  assign head_nxt = mem[rd_nxt];

  always_comb begin
    cnt_n = count;
    case ({push, pull})
      2'b10:   cnt_n = count + 1'b1;
      2'b01:   cnt_n = count - 1'b1;
      default: cnt_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pull) rd_ptr <= rd_nxt;
      count <= cnt_n;
    end
  end

`ifdef BUS_FIFO_ALMOST_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (cnt_n >= (AW+1)'(DEPTH - 2));
      almost_empty <= (cnt_n <= (AW+1)'(1));
    end
  end
`endif

endmodule

// File: rtl/bus_fifo_latch_drv.sv
// Bus FIFO feeding an octal n-latch: arbitrates for the bus and sequences d/g/oe_.
// Define BUS_FIFO_ALMOST_EN to add the almost_full/almost_empty outputs.
module bus_fifo_latch_drv
  import am29_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int HOLD_CYC = 2,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
`ifdef BUS_FIFO_ALMOST_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_g,
  output logic             lat_oe_
);

  localparam int HW = clog2(HOLD_CYC) + 1;

  state_t           state;
  state_t           state_n;
  logic [HW-1:0]    hold;
  logic [HW-1:0]    hold_n;
  logic [WIDTH-1:0] lat_d_n;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nxt;
  logic             pop;

  bus_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .pop          (pop),
    .wdata        (din),
    .head         (head),
    .head_nxt     (head_nxt),
    .full         (full),
    .empty        (empty),
`ifdef BUS_FIFO_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .count        (count)
  );

  always_comb begin
    state_n = state;
    hold_n  = hold;
    lat_d_n = lat_d;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) state_n = REQ;
      REQ: begin
        if (bus_gnt) begin
          state_n = LOAD;
          lat_d_n = head;
        end
      end
      LOAD: begin
        if (!bus_gnt) begin
          state_n = REQ;
        end else begin
          state_n = DRIVE;
          hold_n  = '0;
        end
      end
      DRIVE: begin
        if (!bus_gnt) begin
          state_n = REQ;
        end else if (hold == HW'(HOLD_CYC - 1)) begin
          pop = 1'b1;
          // Head pops on this edge, so the back-to-back word is the one behind it.
          if (count > (AW+1)'(1)) begin
            state_n = LOAD;
            lat_d_n = head_nxt;
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_n = hold + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Latch controls are decoded from the next state so they stay glitch-free registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hold    <= '0;
      lat_d   <= '0;
      lat_g   <= 1'b0;
      lat_oe_ <= 1'b1;
      bus_req <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_n;
      hold    <= hold_n;
      lat_d   <= lat_d_n;
      lat_g   <= (state_n == LOAD);
      lat_oe_ <= (state_n != DRIVE);
      bus_req <= (state_n != IDLE);
      ovf     <= ovf | (wr & full);
    end
  end

endmodule

// File: tb/tb_bus_fifo_latch_drv.sv
// Scoreboard bench for bus_fifo_latch_drv; words queued on write, checked while driven.
module tb_bus_fifo_latch_drv;

  localparam int WIDTH    = 8;
  localparam int DEPTH    = 16;
  localparam int HOLD_CYC = 2;
  localparam int AW       = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             ovf;
`ifdef BUS_FIFO_ALMOST_EN
  logic             almost_full;
  logic             almost_empty;
`endif
  logic             bus_req;
  logic             bus_gnt;
  logic [WIDTH-1:0] lat_d;
  logic             lat_g;
  logic             lat_oe_;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];
  int pops = 0;
  int drv_starts = 0;
  int run = 0;
  logic prev_oe = 1'b1;
  logic [WIDTH-1:0] prev_d = '0;

  always #5 clk = ~clk;

  bus_fifo_latch_drv #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .HOLD_CYC (HOLD_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .din          (din),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
`ifdef BUS_FIFO_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .bus_req      (bus_req),
    .bus_gnt      (bus_gnt),
    .lat_d        (lat_d),
    .lat_g        (lat_g),
    .lat_oe_      (lat_oe_)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive monitor: every enabled cycle must show the scoreboard head; HOLD_CYC
  // consecutive enabled cycles complete the word.
  always @(negedge clk) begin
    if (!rst) begin
      check("inv_g_oe", 32'(lat_g & ~lat_oe_), 32'd0);
      if (!lat_oe_) begin
        if (prev_oe) drv_starts++;
        else check("d_stable", 32'(lat_d), 32'(prev_d));
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          check("drv_data", 32'(lat_d), 32'(sb[0]));
          run++;
          if (run == HOLD_CYC) begin
            void'(sb.pop_front());
            pops++;
            run = 0;
          end
        end
      end else begin
        run = 0;
      end
    end else begin
      run = 0;
    end
    prev_oe = lat_oe_;
    prev_d  = lat_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d, input bit acc);
    wr  = 1'b1;
    din = d;
    if (acc) sb.push_back(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(empty && !bus_req && sb.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_drive(input string tag, input int budget);
    int n;
    n = 0;
    while (lat_oe_ && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int p0;
    int s0;
    int loads;
    int gaps;
    int max_cnt;
    logic [WIDTH-1:0] bw [3];

    rst = 1'b1; wr = 1'b0; din = '0; bus_gnt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_oe", 32'(lat_oe_), 32'd1);
    check("rst_g", 32'(lat_g), 32'd0);
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_d", 32'(lat_d), 32'd0);
`ifdef BUS_FIFO_ALMOST_EN
    check("rst_af", 32'(almost_full), 32'd0);
    check("rst_ae", 32'(almost_empty), 32'd1);
`endif

    // single word
    bus_gnt = 1'b1;
    write_word(8'hA5, 1'b1);
    check("sw_count", 32'(count), 32'd1);
    check("sw_idle", 32'(bus_req), 32'd0);
    tick();
    check("sw_req", 32'(bus_req), 32'd1);
    check("sw_req_oe", 32'(lat_oe_), 32'd1);
    tick();
    check("sw_load_d", 32'(lat_d), 32'hA5);
    check("sw_load_g", 32'(lat_g), 32'd1);
    check("sw_load_oe", 32'(lat_oe_), 32'd1);
    tick();
    check("sw_drv1_oe", 32'(lat_oe_), 32'd0);
    check("sw_drv1_g", 32'(lat_g), 32'd0);
    tick();
    check("sw_drv2_oe", 32'(lat_oe_), 32'd0);
    tick();
    check("sw_end_oe", 32'(lat_oe_), 32'd1);
    check("sw_end_empty", 32'(empty), 32'd1);
    check("sw_end_req", 32'(bus_req), 32'd0);
    check("sw_pops", 32'(pops), 32'd1);

    // overflow
    bus_gnt = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_word(8'(8'h10 + i), 1'b1);
    check("of_full", 32'(full), 32'd1);
    check("of_count16", 32'(count), 32'd16);
`ifdef BUS_FIFO_ALMOST_EN
    check("of_af", 32'(almost_full), 32'd1);
    check("of_ae", 32'(almost_empty), 32'd0);
`endif
    write_word(8'hEE, 1'b0);
    check("of_ovf", 32'(ovf), 32'd1);
    check("of_count_hold", 32'(count), 32'd16);
    tick();
    check("of_ovf_sticky", 32'(ovf), 32'd1);
    p0 = pops;
    bus_gnt = 1'b1;
    wait_idle("of_drain", 200);
    check("of_pops", 32'(pops - p0), 32'd16);
`ifdef BUS_FIFO_ALMOST_EN
    check("of_af_end", 32'(almost_full), 32'd0);
    check("of_ae_end", 32'(almost_empty), 32'd1);
`endif

    // back-to-back
    bw[0] = 8'hA1; bw[1] = 8'hB2; bw[2] = 8'hC3;
    p0 = pops;
    for (int i = 0; i < 3; i++) write_word(bw[i], 1'b1);
    loads = 0;
    gaps  = 0;
    for (int n = 0; n < 30 && sb.size() != 0; n++) begin
      if (lat_g) begin
        if (loads < 3) check("b2b_load_d", 32'(lat_d), 32'(bw[loads]));
        loads++;
      end
      if (!bus_req) gaps++;
      tick();
    end
    wait_idle("b2b_drain", 30);
    check("b2b_loads", 32'(loads), 32'd3);
    check("b2b_gaps", 32'(gaps), 32'd0);
    check("b2b_pops", 32'(pops - p0), 32'd3);

    // grant drop in the first DRIVE cycle
    p0 = pops;
    s0 = drv_starts;
    write_word(8'h3C, 1'b1);
    wait_drive("gd_wait", 20);
    bus_gnt = 1'b0;
    tick();
    check("gd_oe", 32'(lat_oe_), 32'd1);
    check("gd_g", 32'(lat_g), 32'd0);
    check("gd_count", 32'(count), 32'd1);
    check("gd_req", 32'(bus_req), 32'd1);
    tick(); tick();
    check("gd_oe_held", 32'(lat_oe_), 32'd1);
    check("gd_nopop", 32'(pops - p0), 32'd0);
    bus_gnt = 1'b1;
    wait_idle("gd_drain", 30);
    check("gd_pops", 32'(pops - p0), 32'd1);
    check("gd_starts", 32'(drv_starts - s0), 32'd2);

    // reset mid-DRIVE
    write_word(8'h55, 1'b1);
    write_word(8'h66, 1'b1);
    wait_drive("rd_wait", 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("rd_oe", 32'(lat_oe_), 32'd1);
    check("rd_empty", 32'(empty), 32'd1);
    check("rd_count", 32'(count), 32'd0);
    check("rd_req", 32'(bus_req), 32'd0);
    check("rd_ovf", 32'(ovf), 32'd0);

    // wrap: 40 words streamed, one write per word time
    p0 = pops;
    max_cnt = 0;
    bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'(i * 7 + 3), 1'b1);
    bus_gnt = 1'b1;
    for (int i = 4; i < 40; i++) begin
      write_word(8'(i * 7 + 3), 1'b1);
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
      tick();
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    wait_idle("wrap_drain", 300);
    check("wrap_pops", 32'(pops - p0), 32'd40);
    check("wrap_max", 32'(max_cnt <= DEPTH), 32'd1);
    check("wrap_ovf", 32'(ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
